// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC owner, single-outstanding ibus requester, IF/ID producer.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt performance counters.
package core_pkg;
  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        is_bubble;
  } fetch_data_t;
endpackage

module fetch_unit
  import core_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output fetch_data_t dataF_in,
  output logic        Iwait
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FLUSH,
    S_HOLD
  } state_t;

  state_t      state;
  logic [63:0] pc_q;
  logic [63:0] pend_pc;
  logic [31:0] inst_q;
  logic        hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      pend_pc <= 64'h0;
      inst_q  <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (redirect_valid && iresp_data_ok) begin
            pc_q <= redirect_pc;
          end else if (redirect_valid) begin
            pend_pc <= redirect_pc;
            state   <= S_FLUSH;
          end else if (iresp_data_ok) begin
            inst_q <= iresp_data;
            state  <= S_HOLD;
          end
        end
        // request stays on the bus until it completes, then is discarded
        S_FLUSH: begin
          if (iresp_data_ok) begin
            pc_q  <= redirect_valid ? redirect_pc : pend_pc;
            state <= S_REQ;
          end else if (redirect_valid) begin
            pend_pc <= redirect_pc;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_q  <= redirect_pc;
            state <= S_REQ;
          end else if (!stall) begin
            pc_q  <= pc_q + 64'd4;
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hold       = (state == S_HOLD);
  assign ireq_valid = (state == S_REQ) || (state == S_FLUSH);
  assign ireq_addr  = pc_q;
  assign Iwait      = !hold;

  assign dataF_in.raw_instr = hold ? inst_q : 32'h0;
  assign dataF_in.pc        = pc_q;
  assign dataF_in.is_bubble = !hold;

`ifdef FETCH_PERF_CNT_EN
  logic consume;
  logic drop;

  assign consume = hold && !stall && !redirect_valid;
  assign drop    = iresp_data_ok &&
                   (((state == S_REQ) && redirect_valid) ||
                    (state == S_FLUSH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (consume) fetch_cnt <= fetch_cnt + 32'd1;
      if (drop) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run
// checked against a program-flow model (next consumed PC, word contents).
module tb_fetch_unit;
  import core_pkg::*;

  localparam logic [63:0] RST = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  fetch_data_t dataF_in;
  logic        Iwait;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(RST)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .dataF_in(dataF_in),
    .Iwait(Iwait)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    fetch_data_t exp;
    reset_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    iresp_data_ok = 1'b0;
    iresp_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    exp = '{raw_instr: 32'h0, pc: RST, is_bubble: 1'b1};
    n_checks++;
    if (ireq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", ireq_valid);
    end
    n_checks++;
    if (ireq_addr !== RST) begin
      n_fail++;
      $display("FAIL reset_addr got %h want %h", ireq_addr, RST);
    end
    n_checks++;
    if (dataF_in !== exp) begin
      n_fail++;
      $display("FAIL reset_data got %h want %h", dataF_in, exp);
    end
    n_checks++;
    if (Iwait !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_iwait got %b want 1", Iwait);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (fetch_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", fetch_cnt, flush_cnt);
    end
`endif
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST) begin
      n_fail++;
      $display("FAIL first_req got %b/%h want 1/%h", ireq_valid, ireq_addr, RST);
    end
  endtask

  task automatic test_basic();
    fetch_data_t exp;
    tick();
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST || dataF_in.is_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_wait got %b/%h/%b want 1/%h/1",
               ireq_valid, ireq_addr, dataF_in.is_bubble, RST);
    end
    iresp_data_ok = 1'b1;
    iresp_data = mem(RST);
    tick();
    iresp_data_ok = 1'b0;
    exp = '{raw_instr: mem(RST), pc: RST, is_bubble: 1'b0};
    n_checks++;
    if (dataF_in !== exp || Iwait !== 1'b0 || ireq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_present got %h/%b/%b want %h/0/0",
               dataF_in, Iwait, ireq_valid, exp);
    end
    tick();
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'd4) begin
      n_fail++;
      $display("FAIL basic_next got %b/%h want 1/%h", ireq_valid, ireq_addr, RST + 64'd4);
    end
  endtask

  task automatic test_stall();
    fetch_data_t exp;
    iresp_data_ok = 1'b1;
    iresp_data = mem(RST + 64'd4);
    tick();
    iresp_data_ok = 1'b0;
    stall = 1'b1;
    exp = '{raw_instr: mem(RST + 64'd4), pc: RST + 64'd4, is_bubble: 1'b0};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dataF_in !== exp || ireq_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got %h/%b want %h/0", i, dataF_in, ireq_valid, exp);
      end
      if (i == 3) stall = 1'b0;
      tick();
    end
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'd8) begin
      n_fail++;
      $display("FAIL stall_next got %b/%h want 1/%h", ireq_valid, ireq_addr, RST + 64'd8);
    end
  endtask

  task automatic test_redirect_flush();
    fetch_data_t exp;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = RST + 64'h100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'd8 || dataF_in.is_bubble !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_hold[%0d] got %b/%h/%b want 1/%h/1",
                 i, ireq_valid, ireq_addr, dataF_in.is_bubble, RST + 64'd8);
      end
      if (i == 1) begin
        iresp_data_ok = 1'b1;
        iresp_data = mem(RST + 64'd8);
      end
      tick();
    end
    iresp_data_ok = 1'b0;
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h100 || dataF_in.is_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_target got %b/%h/%b want 1/%h/1",
               ireq_valid, ireq_addr, dataF_in.is_bubble, RST + 64'h100);
    end
    iresp_data_ok = 1'b1;
    iresp_data = mem(RST + 64'h100);
    tick();
    iresp_data_ok = 1'b0;
    exp = '{raw_instr: mem(RST + 64'h100), pc: RST + 64'h100, is_bubble: 1'b0};
    n_checks++;
    if (dataF_in !== exp) begin
      n_fail++;
      $display("FAIL flush_present got %h want %h", dataF_in, exp);
    end
    tick();
  endtask

  task automatic test_redirect_same();
    redirect_valid = 1'b1;
    redirect_pc = RST + 64'h200;
    iresp_data_ok = 1'b1;
    iresp_data = mem(RST + 64'h104);
    tick();
    redirect_valid = 1'b0;
    iresp_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (dataF_in.is_bubble !== 1'b1 || Iwait !== 1'b1 ||
          ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h200) begin
        n_fail++;
        $display("FAIL same_cycle[%0d] got %b/%b/%b/%h want 1/1/1/%h",
                 i, dataF_in.is_bubble, Iwait, ireq_valid, ireq_addr, RST + 64'h200);
      end
      tick();
    end
  endtask

  task automatic test_hold_redirect();
    iresp_data_ok = 1'b1;
    iresp_data = mem(RST + 64'h200);
    tick();
    stall = 1'b1;
    iresp_data = 32'hDEAD_BEEF;
    tick();
    iresp_data_ok = 1'b0;
    n_checks++;
    if (dataF_in.raw_instr !== mem(RST + 64'h200) || dataF_in.is_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_stray got %h/%b want %h/0",
               dataF_in.raw_instr, dataF_in.is_bubble, mem(RST + 64'h200));
    end
    redirect_valid = 1'b1;
    redirect_pc = RST + 64'h300;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h300 || dataF_in.is_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_redirect got %b/%h/%b want 1/%h/1",
               ireq_valid, ireq_addr, dataF_in.is_bubble, RST + 64'h300);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] top;
    top = 64'hFFFF_FFFF_FFFF_FFFC;
    redirect_valid = 1'b1;
    redirect_pc = top;
    iresp_data_ok = 1'b1;
    iresp_data = mem(RST + 64'h300);
    tick();
    redirect_valid = 1'b0;
    iresp_data = mem(top);
    tick();
    iresp_data_ok = 1'b0;
    n_checks++;
    if (dataF_in.pc !== top || dataF_in.raw_instr !== mem(top) || dataF_in.is_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_present got %h want pc %h", dataF_in, top);
    end
    tick();
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap_next got %b/%h want 1/0", ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ireq_valid !== 1'b0 || ireq_addr !== RST) begin
      n_fail++;
      $display("FAIL mid_reset got %b/%h want 0/%h", ireq_valid, ireq_addr, RST);
    end
    iresp_data_ok = 1'b1;
    iresp_data = 32'h1234_5678;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST || dataF_in.is_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_restart got %b/%h/%b want 1/%h/1",
               ireq_valid, ireq_addr, dataF_in.is_bubble, RST);
    end
    iresp_data_ok = 1'b0;
    tick();
    n_checks++;
    if (dataF_in.is_bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_stray got bubble %b want 1", dataF_in.is_bubble);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_pc;
    logic [63:0] req_addr;
    logic        in_req;
    logic        tainted;
    logic        shown;
    int          lat;
    int          consumed;
    int          drops;
    reset_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    iresp_data_ok = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    exp_pc = RST;
    in_req = 1'b0;
    tainted = 1'b0;
    req_addr = 64'h0;
    lat = 0;
    consumed = 0;
    drops = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ireq_valid) begin
        if (in_req) begin
          n_checks++;
          if (ireq_addr !== req_addr) begin
            n_fail++;
            $display("FAIL rnd_addr_stable cyc %0d got %h want %h", cyc, ireq_addr, req_addr);
          end
        end else begin
          in_req = 1'b1;
          req_addr = ireq_addr;
          lat = int'($urandom_range(0, 3));
          tainted = 1'b0;
        end
      end
      shown = !dataF_in.is_bubble;
      if (shown) begin
        n_checks++;
        if (dataF_in.pc !== exp_pc || dataF_in.raw_instr !== mem(exp_pc)) begin
          n_fail++;
          $display("FAIL rnd_instr cyc %0d got %h/%h want %h/%h",
                   cyc, dataF_in.pc, dataF_in.raw_instr, exp_pc, mem(exp_pc));
        end
      end
      stall = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = {$urandom, $urandom} & ~64'h3;
      if (in_req && lat == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data = mem(req_addr);
      end else begin
        iresp_data_ok = !in_req && ($urandom_range(0, 5) == 0);
        iresp_data = $urandom;
        if (in_req) lat--;
      end
      if (in_req && redirect_valid) tainted = 1'b1;
      if (in_req && iresp_data_ok) begin
        if (tainted) drops++;
        in_req = 1'b0;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      else if (shown && !stall) begin
        exp_pc = dataF_in.pc + 64'd4;
        consumed++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    iresp_data_ok = 1'b0;
    n_checks++;
    if (consumed < 50) begin
      n_fail++;
      $display("FAIL rnd_progress got %0d consumed want >= 50", consumed);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (fetch_cnt !== 32'(consumed)) begin
      n_fail++;
      $display("FAIL rnd_fetch_cnt got %0d want %0d", fetch_cnt, consumed);
    end
    n_checks++;
    if (flush_cnt !== 32'(drops)) begin
      n_fail++;
      $display("FAIL rnd_flush_cnt got %0d want %0d", flush_cnt, drops);
    end
`else
    if (drops < 0) $display("drops %0d", drops);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_flush();
    test_redirect_same();
    test_hold_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage: owns the PC, drives the instruction-bus request side, and produces one `fetch_data_t` per cycle for the IF/ID pipeline register. It is the producing end of the fetch interface. It issues one outstanding ibus request at a time, buffers the returned word until the decode side is free, and discards in-flight responses on a control-flow redirect.

## Interface
- `RESET_PC`, default 64'h8000_0000: first fetch address after reset.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: downstream cannot accept this cycle (`Dwait || exe_is_waiting`).
- `redirect_valid` in 1: single-cycle redirect pulse (branch/jump resolved).
- `redirect_pc` in 64: redirect target, valid with `redirect_valid`.
- `ireq_valid` out 1: ibus request valid.
- `ireq_addr` out 64: ibus request address.
- `iresp_data_ok` in 1: response word valid this cycle; completes the request.
- `iresp_data` in 32: response instruction word.
- `dataF_in` out `fetch_data_t`: {`raw_instr`, `pc`, `is_bubble`} to IF/ID.
- `Iwait` out 1: fetch has no instruction to offer this cycle.

## Operation
- States: S_IDLE, S_REQ, S_FLUSH, S_HOLD. `pc_q` holds the current fetch PC. `pend_pc` holds the redirect target during S_FLUSH. `inst_q` holds the buffered word.
- S_IDLE: `ireq_valid`=0. Go to S_REQ unconditionally on the next edge.
- S_REQ: `ireq_valid`=1, `ireq_addr`=`pc_q`.
  - `redirect_valid && iresp_data_ok`: drop the word, `pc_q`<=`redirect_pc`, stay in S_REQ.
  - `redirect_valid` without `iresp_data_ok`: `pend_pc`<=`redirect_pc`, go to S_FLUSH.
  - `iresp_data_ok`: `inst_q`<=`iresp_data`, go to S_HOLD. This happens whatever the state of `stall`.
  - Otherwise stay in S_REQ.
- S_FLUSH: `ireq_valid`=1, `ireq_addr`=old `pc_q` (the request is held until it completes).
  - A further `redirect_valid` overwrites `pend_pc`.
  - On `iresp_data_ok`: drop the word, `pc_q`<=`pend_pc`, or `redirect_pc` if a redirect arrives in the same cycle, then go to S_REQ.
- S_HOLD: `ireq_valid`=0. Presents `inst_q`.
  - `redirect_valid` takes priority: `pc_q`<=`redirect_pc`, go to S_REQ.
  - Else if `!stall`: the word is consumed, `pc_q`<=`pc_q`+4, go to S_REQ.
  - Else stay in S_HOLD.
- Output in S_HOLD: `dataF_in`={`inst_q`, `pc_q`, `is_bubble`=0}, `Iwait`=0.
- Output in all other states: `dataF_in`={32'h0, `pc_q`, `is_bubble`=1}, `Iwait`=1.
- PC arithmetic: 64-bit modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- `redirect_pc` is used as given, with no alignment fixup.

## Timing
- Reset (async, while `reset_n`=0):
  - state=S_IDLE, `pc_q`=`RESET_PC`, `pend_pc`=0, `inst_q`=0.
  - `ireq_valid`=0, `ireq_addr`=`RESET_PC`.
  - `dataF_in`={0, `RESET_PC`, 1}, `Iwait`=1.
- First request appears one cycle after reset release.
- Bus rule: while `ireq_valid`=1, `ireq_addr` is stable until the cycle `iresp_data_ok`=1. `ireq_valid` never drops mid-request except under reset.
- Latency from `iresp_data_ok` (cycle N) to the instruction presented with `is_bubble`=0: cycle N+1.
- Minimum gap from consumption (cycle M) to the next request: request issued in cycle M+1.
- Redirect latency: the new PC is requested in the cycle after the redirect when no request is outstanding, otherwise in the cycle after the outstanding `iresp_data_ok`.
- `reset_n` low mid-request: `ireq_valid` drops immediately (asynchronously). The bus must tolerate the abandoned request. Any late `iresp_data_ok` arriving in S_IDLE is ignored.
- `iresp_data_ok` in S_IDLE or S_HOLD is ignored.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two outputs, `fetch_cnt` (out 32) and `flush_cnt` (out 32). Both reset to 0 and wrap at 2^32.
  - `fetch_cnt` increments on each consumed instruction (S_HOLD && `!stall` && `!redirect_valid`).
  - `flush_cnt` increments on each dropped response.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then 2-cycle memory latency, no stall → `ireq_addr`=8000_0000 held until data_ok. Next cycle `dataF_in`={word, 8000_0000, 0}. Next request to 8000_0004 one cycle later.
- `stall`=1 for 3 cycles in S_HOLD → the same {word, pc, 0} is presented for 4 cycles with `ireq_valid`=0. The PC advances only after `stall` drops.
- Redirect to 8000_0100 one cycle after a request to 8000_0004 is issued, data_ok 2 cycles later → `ireq_addr` stays 8000_0004 until data_ok, the word is dropped, then a request to 8000_0100. `is_bubble`=1 throughout.
- `redirect_valid` and `iresp_data_ok` in the same S_REQ cycle → no instruction presented. Next request is to `redirect_pc`.
- `reset_n` pulled low while a request is outstanding → `ireq_valid`=0 at once. After release, a request to `RESET_PC`; a stray data_ok during S_IDLE produces no instruction.
- With `FETCH_PERF_CNT_EN`: 5 consumed instructions and 2 dropped responses → `fetch_cnt`=5, `flush_cnt`=2.
